// File: rtl/msg_serializer_if.sv
// Parsed-message types shared with the parser, plus the serializer's message/byte handshake bundle.
// Both links are valid/ready: a word moves on any cycle where valid && ready, and valid holds until it does.
package parser_defs;
    typedef struct packed {
        logic [7:0]  msg_type;
        logic [7:0]  stock_id;
        logic [31:0] order_id;
        logic [31:0] price;
        logic [31:0] quantity;
        logic [15:0] padding;
    } parsed_msg_t;

    localparam logic [7:0] MSG_DELETE = 8'h44;
endpackage

interface msg_serializer_if;
    logic                    msg_valid;
    logic                    msg_ready;
    parser_defs::parsed_msg_t msg_in;
    logic [7:0]              byte_out;
    logic                    byte_valid;
    logic                    byte_ready;
    logic                    msg_sent;

    modport master (
        output msg_valid, msg_in, byte_ready,
        input  msg_ready, byte_out, byte_valid, msg_sent
    );

    modport slave (
        input  msg_valid, msg_in, byte_ready,
        output msg_ready, byte_out, byte_valid, msg_sent
    );
endinterface

// File: rtl/msg_serializer.sv
// Serializes one parsed message into a big-endian byte stream followed by a 8'h00 separator.
// Optional MSG_CHECKSUM_EN: padding bytes 14-15 carry the 16-bit sum of bytes 0-13.
module msg_serializer (
    input  logic              clk,
    input  logic              reset,
    msg_serializer_if.slave   bus,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        SEP  = 2'd2
    } state_t;

    // Must match parser_defs::MSG_DELETE.
    localparam logic [7:0] MSG_DELETE = 8'h44;

    state_t        state, state_nxt;
    logic [127:0]  hold_q;
    logic [3:0]    cnt_q;
    logic [3:0]    last_idx_q;
    logic [127:0]  msg_vec;
    logic [127:0]  hold_shift;
    logic [15:0]   pad;
    logic          accept;
    logic          send_xfer;
    logic          unused_pad_in;

    assign msg_vec       = bus.msg_in;
    assign unused_pad_in = ^msg_vec[15:0];
    assign dbg_state     = state;
    assign accept        = (state == IDLE) && bus.msg_valid;
    assign send_xfer     = (state == SEND) && bus.byte_ready;
    assign hold_shift    = hold_q << {cnt_q, 3'b000};

`ifdef MSG_CHECKSUM_EN
    always_comb begin
        pad = 16'h0000;
        for (int i = 0; i < 14; i++) begin
            pad = pad + {8'h00, msg_vec[127 - 8*i -: 8]};
        end
    end
`else
    assign pad = 16'h0000;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.msg_ready  = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_out   = 8'h00;
        bus.msg_sent   = 1'b0;
        case (state)
            IDLE: begin
                bus.msg_ready = 1'b1;
                if (bus.msg_valid) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                bus.byte_valid = 1'b1;
                bus.byte_out   = hold_shift[127:120];
                if (bus.byte_ready && (cnt_q == last_idx_q)) begin
                    bus.msg_sent = 1'b1;
                    state_nxt    = SEP;
                end
            end
            SEP: begin
                bus.byte_valid = 1'b1;
                if (bus.byte_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The counter stops at last_idx instead of wrapping; SEP takes over from there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q     <= '0;
            cnt_q      <= '0;
            last_idx_q <= '0;
        end else if (accept) begin
            hold_q     <= {msg_vec[127:16], pad};
            cnt_q      <= '0;
            last_idx_q <= (msg_vec[127:120] == MSG_DELETE) ? 4'd5 : 4'd15;
        end else if (send_xfer && (cnt_q != last_idx_q)) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end
endmodule

// File: tb/tb_msg_serializer.sv
// Directed bench for msg_serializer: full, delete, backpressure, checksum padding and mid-message reset.
module tb_msg_serializer;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    msg_serializer_if bus();

    msg_serializer dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_msg(input logic [127:0] m);
        int k;
        @(negedge clk);
        bus.msg_in    = m;
        bus.msg_valid = 1'b1;
        k = 0;
        while (!bus.msg_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("accept_ready", bus.msg_ready, 1);
        @(negedge clk);
        bus.msg_valid = 1'b0;
        bus.msg_in    = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Starts on the negedge of the first cycle after acceptance; t counts cycles from acceptance.
    task automatic collect(input int n, input int stall_idx, input int stall_n, input int exp_sent_idx);
        int got_n = 0;
        int t = 0;
        int sent_cnt = 0;
        int sent_at = -1;
        int stall_left = stall_n;
        int hold_cnt = 0;
        int last_t = 0;
        logic [7:0] e;
        while (got_n < n && t < 200) begin
            t++;
            if (got_n == stall_idx && stall_left > 0) begin
                bus.byte_ready = 1'b0;
                stall_left--;
            end else begin
                bus.byte_ready = 1'b1;
            end
            #1;
            if (got_n == stall_idx && bus.byte_valid && bus.byte_out == exp_q[0]) hold_cnt++;
            if (!bus.byte_ready) begin
                check($sformatf("stall_valid%0d", t), bus.byte_valid, 1);
                check($sformatf("stall_byte%0d", t), bus.byte_out, exp_q[0]);
            end
            if (bus.msg_sent) begin
                sent_cnt++;
                sent_at = got_n;
            end
            if (bus.byte_valid && bus.byte_ready) begin
                e = exp_q.pop_front();
                check($sformatf("byte%0d", got_n), bus.byte_out, e);
                got_n++;
                last_t = t;
            end
            @(negedge clk);
        end
        check("xfer_count", got_n, n);
        check("last_xfer_cycle", last_t, n + stall_n);
        check("sent_pulses", sent_cnt, (exp_sent_idx >= 0) ? 1 : 0);
        check("sent_idx", sent_at, exp_sent_idx);
        if (stall_n > 0) check("stall_hold", hold_cnt, stall_n + 1);
    endtask

    task automatic check_idle(input string tag);
        #1;
        check({tag, "_ready"}, bus.msg_ready, 1);
        check({tag, "_valid"}, bus.byte_valid, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    initial begin
        bus.msg_valid  = 1'b0;
        bus.msg_in     = '0;
        bus.byte_ready = 1'b0;
        reset          = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", bus.msg_ready, 1);
        check("rst_valid", bus.byte_valid, 0);
        check("rst_byte", bus.byte_out, 8'h00);
        check("rst_sent", bus.msg_sent, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b0;

        // Full message; the input padding 16'hBEEF must not appear on the wire.
`ifdef MSG_CHECKSUM_EN
        exp_q = {8'h41, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h64,
                 8'h00, 8'h00, 8'h00, 8'h0A, 8'h01, 8'h5E, 8'h00};
`else
        exp_q = {8'h41, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h64,
                 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00};
`endif
        send_msg({8'h41, 8'h05, 32'h11223344, 32'h00000064, 32'h0000000A, 16'hBEEF});
        collect(17, -1, 0, 15);
        check_idle("full_end");

        // Delete message: six bytes then separator.
        exp_q = {8'h44, 8'h07, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
        send_msg({8'h44, 8'h07, 32'hDEADBEEF, 32'h12345678, 32'h9ABCDEF0, 16'h0000});
        collect(7, -1, 0, 5);
        check_idle("del_end");

        // Same full message with three stall cycles at byte index 4.
`ifdef MSG_CHECKSUM_EN
        exp_q = {8'h41, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h64,
                 8'h00, 8'h00, 8'h00, 8'h0A, 8'h01, 8'h5E, 8'h00};
`else
        exp_q = {8'h41, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h64,
                 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00};
`endif
        send_msg({8'h41, 8'h05, 32'h11223344, 32'h00000064, 32'h0000000A, 16'h0000});
        collect(17, 4, 3, 15);
        check_idle("stall_end");

        // Small-field message: checksum 0x41+0x05+1+2+3 = 0x004C.
`ifdef MSG_CHECKSUM_EN
        exp_q = {8'h41, 8'h05, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
                 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h4C, 8'h00};
`else
        exp_q = {8'h41, 8'h05, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
                 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
`endif
        send_msg({8'h41, 8'h05, 32'h00000001, 32'h00000002, 32'h00000003, 16'hFFFF});
        collect(17, -1, 0, 15);
        check_idle("csum_end");

        // Abandon a message at byte index 8 with reset.
        exp_q = {8'h41, 8'h06, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h01, 8'h02};
        send_msg({8'h41, 8'h06, 32'hCAFEBABE, 32'h01020304, 32'h05060708, 16'h0000});
        collect(8, -1, 0, -1);
        #1;
        check("mid_valid", bus.byte_valid, 1);
        check("mid_byte8", bus.byte_out, 8'h03);
        reset = 1'b1;
        check_idle("mid_rst");
        @(negedge clk);
        reset = 1'b0;

        exp_q = {8'h44, 8'h09, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
        send_msg({8'h44, 8'h09, 32'h01020304, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h0000});
        collect(7, -1, 0, 5);
        check_idle("post_rst_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
